shr_6sipo: RTL and testbench

SHR_6SIPO -- requirements
Module: shr_6sipo

---
 rtl/shr_pkg.sv | 22 ++
 rtl/shr_6sipo.sv | 96 +++++++++
 tb/tb_shr_6sipo.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/shr_pkg.sv
// Shared constants and types for the 6-bit LSB-first serial shifters.
// Holds word/counter widths and the receive FSM state encoding.
package shr_pkg;

    localparam int WORD_W = 6;
    localparam int CNT_W  = 3;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Complete receiver state in one register so checkers can bind to a single signal.
    typedef struct packed {
        state_t              fsm;
        logic [CNT_W-1:0]    cnt;
        logic [WORD_W-1:0]   sr;
    } rx_state_t;

endpackage

// File: rtl/shr_6sipo.sv
// 6-bit LSB-first serial-in/parallel-out receiver with frame SYNC, a held output
// word with VALID/ACK hand-off, sticky overrun and a truncation (FERR) pulse.
module shr_6sipo
    import shr_pkg::*;
#(
    parameter bit OVR_KEEP = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              SYNC,
    input  logic              DIN,
    input  logic              ACK,
    output logic [WORD_W-1:0] DOUT,
    output logic              VALID,
    output logic              OVR,
    output logic              FERR
);

    rx_state_t         st;
    rx_state_t         st_nxt;
    logic              complete;
    logic              trunc;
    logic [WORD_W-1:0] word;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            st <= '{fsm: IDLE, cnt: '0, sr: '0};
        end else begin
            st <= st_nxt;
        end
    end

    // New bits enter at the top so the first bit of a word ends up in bit 0.
    always_comb begin
        st_nxt   = st;
        complete = 1'b0;
        trunc    = 1'b0;
        word     = {DIN, st.sr[WORD_W-1:1]};
        if (EN) begin
            case (st.fsm)
                IDLE: begin
                    if (SYNC) begin
                        st_nxt.sr  = word;
                        st_nxt.cnt = CNT_W'(1);
                        st_nxt.fsm = SHIFT;
                    end
                end
                SHIFT: begin
                    st_nxt.sr = word;
                    if (SYNC) begin
                        st_nxt.cnt = CNT_W'(1);
                        trunc      = (st.cnt != '0);
                    end else if (st.cnt == LAST_BIT) begin
                        st_nxt.cnt = '0;
                        complete   = 1'b1;
                    end else begin
                        st_nxt.cnt = st.cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Hand-off: VALID means DOUT holds a word not yet taken; the word is taken on
    // any edge with VALID=1 and ACK=1. ACK while VALID=0 is ignored. A word that
    // completes on the taking edge replaces it directly and VALID stays high.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            DOUT  <= '0;
            VALID <= 1'b0;
            OVR   <= 1'b0;
            FERR  <= 1'b0;
        end else begin
            FERR <= trunc;
            if (complete) begin
                if (!VALID || ACK) begin
                    DOUT  <= word;
                    VALID <= 1'b1;
                    if (VALID) begin
                        OVR <= 1'b0;
                    end
                end else begin
                    OVR <= 1'b1;
                    if (!OVR_KEEP) begin
                        DOUT <= word;
                    end
                end
            end else if (VALID && ACK) begin
                VALID <= 1'b0;
                OVR   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shr_6sipo.sv
// Bench for shr_6sipo: two instances (keep / overwrite on overrun) share stimulus;
// word-level table rows go through an expected-value queue, corner cases are hand-written.
module tb_shr_6sipo;
    import shr_pkg::*;

    logic clk;
    logic rst;
    logic en;
    logic sync;
    logic din;
    logic ack;

    logic [5:0] dout_k, dout_o;
    logic       valid_k, valid_o;
    logic       ovr_k, ovr_o;
    logic       ferr_k, ferr_o;

    shr_6sipo #(.OVR_KEEP(1'b1)) dut_keep (
        .CLK(clk), .RST(rst), .EN(en), .SYNC(sync), .DIN(din), .ACK(ack),
        .DOUT(dout_k), .VALID(valid_k), .OVR(ovr_k), .FERR(ferr_k)
    );

    shr_6sipo #(.OVR_KEEP(1'b0)) dut_over (
        .CLK(clk), .RST(rst), .EN(en), .SYNC(sync), .DIN(din), .ACK(ack),
        .DOUT(dout_o), .VALID(valid_o), .OVR(ovr_o), .FERR(ferr_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic       ack_only;
        logic [5:0] word;
        logic       sync;
        logic       ack;
        logic [15:0] exp;
    } vec_t;

    vec_t        vecs[12];
    logic [15:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [15:0] pk(logic [5:0] dk, logic vk, logic ok,
                                       logic [5:0] d0, logic v0, logic o0);
        return {dk, vk, ok, d0, v0, o0};
    endfunction

    function automatic logic [15:0] obs();
        return {dout_k, valid_k, ovr_k, dout_o, valid_o, ovr_o};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_ferr(input string name, input logic e);
        check(name, {14'b0, ferr_k, ferr_o}, {14'b0, e, e});
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_bit(input logic b, input logic s, input logic a);
        @(negedge clk);
        en   = 1'b1;
        sync = s;
        din  = b;
        ack  = a;
        @(posedge clk);
        #1;
        en   = 1'b0;
        sync = 1'b0;
        ack  = 1'b0;
    endtask

    // EN=0 cycle with junk on SYNC/DIN; must leave all state frozen.
    task automatic bubble();
        @(negedge clk);
        en   = 1'b0;
        ack  = 1'b0;
        sync = 1'($urandom_range(0, 1));
        din  = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        sync = 1'b0;
    endtask

    task automatic ack_cycle();
        @(negedge clk);
        en  = 1'b0;
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
    endtask

    task automatic send_word(input logic [5:0] w, input logic s_first, input logic a_last);
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 3) == 0) bubble();
            drive_bit(w[i], (i == 0) && s_first, (i == 5) && a_last);
        end
    endtask

    // ---------------- test ----------------
    initial begin
        logic [15:0] e;

        rst  = 1'b1;
        en   = 1'b0;
        sync = 1'b0;
        din  = 1'b0;
        ack  = 1'b0;

        vecs[0]  = '{1'b0, 6'h2D, 1'b1, 1'b0, pk(6'h2D, 1, 0, 6'h2D, 1, 0)};
        vecs[1]  = '{1'b0, 6'h15, 1'b0, 1'b1, pk(6'h15, 1, 0, 6'h15, 1, 0)};
        vecs[2]  = '{1'b1, 6'h00, 1'b0, 1'b1, pk(6'h15, 0, 0, 6'h15, 0, 0)};
        vecs[3]  = '{1'b0, 6'h2D, 1'b0, 1'b0, pk(6'h2D, 1, 0, 6'h2D, 1, 0)};
        vecs[4]  = '{1'b0, 6'h3F, 1'b0, 1'b0, pk(6'h2D, 1, 1, 6'h3F, 1, 1)};
        vecs[5]  = '{1'b1, 6'h00, 1'b0, 1'b1, pk(6'h2D, 0, 0, 6'h3F, 0, 0)};
        vecs[6]  = '{1'b1, 6'h00, 1'b0, 1'b1, pk(6'h2D, 0, 0, 6'h3F, 0, 0)};
        vecs[7]  = '{1'b0, 6'h00, 1'b0, 1'b0, pk(6'h00, 1, 0, 6'h00, 1, 0)};
        vecs[8]  = '{1'b0, 6'h3F, 1'b0, 1'b1, pk(6'h3F, 1, 0, 6'h3F, 1, 0)};
        vecs[9]  = '{1'b0, 6'h2A, 1'b0, 1'b0, pk(6'h3F, 1, 1, 6'h2A, 1, 1)};
        vecs[10] = '{1'b0, 6'h01, 1'b1, 1'b1, pk(6'h01, 1, 0, 6'h01, 1, 0)};
        vecs[11] = '{1'b1, 6'h00, 1'b0, 1'b1, pk(6'h01, 0, 0, 6'h01, 0, 0)};

        // Asynchronous reset, visible before any clock edge.
        #2 rst = 1'b0;
        #1;
        check("reset_outputs", obs(), 16'h0000);
        check_ferr("reset_ferr", 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // SYNC without EN, then bits without SYNC: nothing may be received.
        @(negedge clk);
        sync = 1'b1;
        din  = 1'b1;
        @(posedge clk);
        #1 sync = 1'b0;
        for (int i = 0; i < 6; i++) drive_bit(1'b1, 1'b0, 1'b0);
        check("idle_ignores_bits", obs(), 16'h0000);

        // Table-driven words and ACK cycles.
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back(vecs[i].exp);
            if (vecs[i].ack_only) ack_cycle();
            else send_word(vecs[i].word, vecs[i].sync, vecs[i].ack);
            e = exp_q.pop_front();
            check($sformatf("row%0d", i), obs(), e);
        end

        // Truncation: SYNC at a word boundary is clean, SYNC mid-word pulses FERR once.
        drive_bit(1'b1, 1'b1, 1'b0);
        check_ferr("sync_boundary_no_ferr", 1'b0);
        drive_bit(1'b1, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b1, 1'b0);
        check_ferr("trunc_ferr_high", 1'b1);
        drive_bit(1'b1, 1'b0, 1'b0);
        check_ferr("trunc_ferr_one_cycle", 1'b0);
        drive_bit(1'b0, 1'b0, 1'b0);
        drive_bit(1'b1, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b0, 1'b0);
        check("trunc_before_last", obs(), pk(6'h01, 0, 0, 6'h01, 0, 0));
        drive_bit(1'b0, 1'b0, 1'b0);
        check("trunc_word", obs(), pk(6'h0A, 1, 0, 6'h0A, 1, 0));

        // Reset in the middle of a word.
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("midword_reset_outputs", obs(), 16'h0000);
        check_ferr("midword_reset_ferr", 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) drive_bit(1'b1, 1'b0, 1'b0);
        check("after_reset_no_sync", obs(), 16'h0000);
        exp_q.push_back(pk(6'h2D, 1, 0, 6'h2D, 1, 0));
        send_word(6'h2D, 1'b1, 1'b0);
        e = exp_q.pop_front();
        check("after_reset_resync", obs(), e);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
